// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared integer-pipeline widths, load funct3 codes and register address type
package riscv_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - picks the byte/half/word out of an aligned load word and sign/zero-extends it
module load_extend
    import riscv_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic [WIDTH-1:0] in_mem_out,
    input  logic [1:0]       in_addr_low,
    input  logic [2:0]       in_load_funct3,
    output logic [WIDTH-1:0] out_data
);
    logic [WIDTH-1:0] byte_shift;
    logic [WIDTH-1:0] half_shift;
    logic [7:0]       byte_val;
    logic [15:0]      half_val;

    // Halfword selection uses only addr_low[1]; a misaligned half offset is ignored.
    assign byte_shift = in_mem_out >> {in_addr_low, 3'b000};
    assign half_shift = in_mem_out >> {in_addr_low[1], 4'b0000};
    assign byte_val   = byte_shift[7:0];
    assign half_val   = half_shift[15:0];

    always_comb begin
        out_data = in_mem_out;
        case (in_load_funct3)
            F3_LB:   out_data = {{(WIDTH-8){byte_val[7]}}, byte_val};
            F3_LH:   out_data = {{(WIDTH-16){half_val[15]}}, half_val};
            F3_LBU:  out_data = {{(WIDTH-8){1'b0}}, byte_val};
            F3_LHU:  out_data = {{(WIDTH-16){1'b0}}, half_val};
            default: out_data = in_mem_out;
        endcase
    end
endmodule

// File: rtl/writeback_regfile.sv
// rtl/writeback_regfile.sv - writeback select, 31-entry register file with two read ports and commit counter
// Optional same-cycle write-through to the read ports: define WB_BYPASS_EN.
module writeback_regfile
    import riscv_pkg::*;
#(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  in_alu_out,
    input  logic [XLEN-1:0]  in_mem_out,
    input  reg_addr_t        in_rd,
    input  logic             in_mem_to_reg,
    input  logic             in_write_enable,
    input  logic [2:0]       in_load_funct3,
    input  logic [1:0]       in_addr_low,
    input  reg_addr_t        in_rs1,
    input  reg_addr_t        in_rs2,
    output logic [XLEN-1:0]  out_rs1_data,
    output logic [XLEN-1:0]  out_rs2_data,
    output logic [XLEN-1:0]  out_wb_data,
    output logic [CNT_W-1:0] out_wb_count
);
    logic [XLEN-1:0] regs [1:31];
    logic [XLEN-1:0] load_data;
    logic            commit;

    load_extend #(.WIDTH(XLEN)) u_load_extend (
        .in_mem_out     (in_mem_out),
        .in_addr_low    (in_addr_low),
        .in_load_funct3 (in_load_funct3),
        .out_data       (load_data)
    );

    assign out_wb_data = in_mem_to_reg ? load_data : in_alu_out;
    assign commit      = in_write_enable && (in_rd != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[in_rd] <= out_wb_data;
        end
    end

    // Counts every write-enabled cycle, x0 targets included.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_wb_count <= '0;
        end else if (in_write_enable) begin
            out_wb_count <= out_wb_count + CNT_W'(1);
        end
    end

    function automatic logic [XLEN-1:0] read_port(input reg_addr_t addr);
        logic [XLEN-1:0] val;
        if (reset || addr == '0) begin
            val = '0;
`ifdef WB_BYPASS_EN
        end else if (commit && addr == in_rd) begin
            val = out_wb_data;
`endif
        end else begin
            val = regs[addr];
        end
        return val;
    endfunction

    assign out_rs1_data = read_port(in_rs1);
    assign out_rs2_data = read_port(in_rs2);
endmodule

// File: tb/tb_writeback_regfile.sv
// tb/tb_writeback_regfile.sv - directed self-checking bench for writeback_regfile (CNT_W=4 to reach wrap)
module tb_writeback_regfile;
    import riscv_pkg::*;

    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [31:0]     alu_out, mem_out;
    reg_addr_t       rd, rs1, rs2;
    logic            mem_to_reg, write_enable;
    logic [2:0]      load_funct3;
    logic [1:0]      addr_low;
    logic [31:0]     rs1_data, rs2_data, wb_data;
    logic [CW-1:0]   wb_count;

    int total = 0;
    int bad   = 0;

    writeback_regfile #(.XLEN(32), .CNT_W(CW)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_alu_out      (alu_out),
        .in_mem_out      (mem_out),
        .in_rd           (rd),
        .in_mem_to_reg   (mem_to_reg),
        .in_write_enable (write_enable),
        .in_load_funct3  (load_funct3),
        .in_addr_low     (addr_low),
        .in_rs1          (rs1),
        .in_rs2          (rs2),
        .out_rs1_data    (rs1_data),
        .out_rs2_data    (rs2_data),
        .out_wb_data     (wb_data),
        .out_wb_count    (wb_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write_alu(input reg_addr_t r, input logic [31:0] v);
        write_enable = 1'b1;
        mem_to_reg   = 1'b0;
        rd           = r;
        alu_out      = v;
        next_cycle();
        write_enable = 1'b0;
    endtask

    task automatic load_case(input string tag, input logic [2:0] f3, input logic [1:0] off,
                             input logic [31:0] exp);
        load_funct3 = f3;
        addr_low    = off;
        #1;
        check(tag, {32'h0, wb_data}, {32'h0, exp});
    endtask

    initial begin
        reset = 1'b1;
        alu_out = '0; mem_out = '0; rd = '0; rs1 = '0; rs2 = '0;
        mem_to_reg = 1'b0; write_enable = 1'b0; load_funct3 = '0; addr_low = '0;
        next_cycle();
        next_cycle();
        reset = 1'b0;

        for (int i = 1; i < 32; i++) begin
            rs1 = reg_addr_t'(i);
            rs2 = reg_addr_t'(32 - i);
            #1;
            check("reset_rs1", {32'h0, rs1_data}, 64'h0);
            check("reset_rs2", {32'h0, rs2_data}, 64'h0);
        end
        check("reset_count", {60'h0, wb_count}, 64'h0);

        write_alu(5'd5, 32'hDEADBEEF);
        rs1 = 5'd5;
        #1;
        check("x5_read", {32'h0, rs1_data}, 64'hDEADBEEF);
        check("count_1", {60'h0, wb_count}, 64'd1);

        write_alu(5'd0, 32'h12345678);
        rs1 = 5'd0;
        #1;
        check("x0_read", {32'h0, rs1_data}, 64'h0);
        check("count_2", {60'h0, wb_count}, 64'd2);

        mem_to_reg = 1'b1;
        mem_out    = 32'h80FF7F01;
        alu_out    = 32'h0BAD0BAD;
        load_case("lb_off1",  F3_LB,  2'd1, 32'h0000007F);
        load_case("lb_off3",  F3_LB,  2'd3, 32'hFFFFFF80);
        load_case("lhu_off2", F3_LHU, 2'd2, 32'h000080FF);
        load_case("lh_off0",  F3_LH,  2'd0, 32'h00007F01);
        load_case("lh_off2",  F3_LH,  2'd2, 32'hFFFF80FF);
        load_case("lh_off3",  F3_LH,  2'd3, 32'hFFFF80FF);
        load_case("lbu_off3", F3_LBU, 2'd3, 32'h00000080);
        load_case("lbu_off0", F3_LBU, 2'd0, 32'h00000001);
        load_case("lw",       F3_LW,  2'd0, 32'h80FF7F01);
        load_case("f3_other", 3'b011, 2'd1, 32'h80FF7F01);
        mem_to_reg = 1'b0;
        #1;
        check("alu_sel", {32'h0, wb_data}, 64'h0BAD0BAD);

        mem_to_reg   = 1'b1;
        load_funct3  = F3_LB;
        addr_low     = 2'd3;
        rd           = 5'd9;
        write_enable = 1'b1;
        next_cycle();
        write_enable = 1'b0;
        mem_to_reg   = 1'b0;
        rs1 = 5'd9;
        #1;
        check("x9_load", {32'h0, rs1_data}, 64'hFFFFFF80);
        check("count_3", {60'h0, wb_count}, 64'd3);

        write_alu(5'd7, 32'h11111111);
        write_enable = 1'b1;
        rd      = 5'd7;
        alu_out = 32'hA5A5A5A5;
        rs1     = 5'd7;
        rs2     = 5'd7;
        #1;
`ifdef WB_BYPASS_EN
        check("same_cycle_rs2", {32'h0, rs2_data}, 64'hA5A5A5A5);
`else
        check("same_cycle_rs2", {32'h0, rs2_data}, 64'h11111111);
`endif
        check("ports_agree", {32'h0, rs1_data}, {32'h0, rs2_data});
        next_cycle();
        write_enable = 1'b0;
        #1;
        check("x7_next", {32'h0, rs2_data}, 64'hA5A5A5A5);
        check("count_5", {60'h0, wb_count}, 64'd5);

        write_enable = 1'b1;
        rd  = 5'd0;
        rs1 = 5'd0;
        #1;
        check("x0_no_bypass", {32'h0, rs1_data}, 64'h0);
        next_cycle();
        write_enable = 1'b0;

        #2;
        reset = 1'b1;
        rs1 = 5'd5;
        rs2 = 5'd7;
        #1;
        check("async_rs1", {32'h0, rs1_data}, 64'h0);
        check("async_rs2", {32'h0, rs2_data}, 64'h0);
        check("async_count", {60'h0, wb_count}, 64'h0);
        write_enable = 1'b1;
        rd      = 5'd3;
        alu_out = 32'hCAFEF00D;
        next_cycle();
        write_enable = 1'b0;
        reset = 1'b0;
        rs1 = 5'd3;
        rs2 = 5'd9;
        #1;
        check("reset_wins_x3", {32'h0, rs1_data}, 64'h0);
        check("reset_x9", {32'h0, rs2_data}, 64'h0);
        check("reset_wins_cnt", {60'h0, wb_count}, 64'h0);

        write_enable = 1'b1;
        rd = 5'd0;
        for (int i = 0; i < 15; i++) next_cycle();
        #1;
        check("count_full", {60'h0, wb_count}, 64'hF);
        next_cycle();
        write_enable = 1'b0;
        #1;
        check("count_wrap", {60'h0, wb_count}, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
